// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared register-file state encoding and default sizes
package regfile_mp_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

endpackage

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear sweep and busy scoreboard
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready_o,
    input  logic                  wen,
    input  logic [AW-1:0]         regW_sel,
    input  logic [XLEN-1:0]       regW_i,
    input  logic [NREAD*AW-1:0]   rd_sel_i,
    output logic [NREAD*XLEN-1:0] rd_data_o,
    output logic [NREAD-1:0]      rd_busy_o,
    input  logic                  busy_set_en,
    input  logic [AW-1:0]         busy_set_sel
);

    rf_state_e         state, state_nxt;
    logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
    logic [NREGS-1:0]  busy, busy_nxt;
    logic              run;
    logic              wr_fire;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    // No reset on storage so it maps onto distributed RAM; the sweep zeroes it.
    logic [XLEN-1:0]   mem [NREGS];

    assign run     = (state == RF_RUN);
    assign ready_o = run;
    assign wr_fire = run && wen && (regW_sel != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= AW'(1);
            busy    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy_nxt    = busy;
        mem_we      = 1'b0;
        mem_waddr   = regW_sel;
        mem_wdata   = regW_i;
        case (state)
            RF_CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clr_cnt;
                mem_wdata   = '0;
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == AW'(NREGS - 1)) begin
                    state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                mem_we = wr_fire;
                if (wen) begin
                    busy_nxt[regW_sel] = 1'b0;
                end
                // Applied after the clear so a same-cycle set wins.
                if (busy_set_en && (busy_set_sel != '0)) begin
                    busy_nxt[busy_set_sel] = 1'b1;
                end
            end
            default: state_nxt = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign sel = rd_sel_i[p*AW +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (run && (sel != '0)) begin
                data = mem[sel];
                bsy  = busy[sel];
`ifdef REGFILE_BYPASS_EN
                if (wr_fire && (sel == regW_sel)) begin
                    data = regW_i;
                    bsy  = busy_set_en && (busy_set_sel == sel);
                end
`endif
            end
        end

        assign rd_data_o[p*XLEN +: XLEN] = data;
        assign rd_busy_o[p]              = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  ready_o;
    logic                  wen;
    logic [AW-1:0]         regW_sel;
    logic [XLEN-1:0]       regW_i;
    logic [NREAD*AW-1:0]   rd_sel_i;
    logic [NREAD*XLEN-1:0] rd_data_o;
    logic [NREAD-1:0]      rd_busy_o;
    logic                  busy_set_en;
    logic [AW-1:0]         busy_set_sel;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready_o      (ready_o),
        .wen          (wen),
        .regW_sel     (regW_sel),
        .regW_i       (regW_i),
        .rd_sel_i     (rd_sel_i),
        .rd_data_o    (rd_data_o),
        .rd_busy_o    (rd_busy_o),
        .busy_set_en  (busy_set_en),
        .busy_set_sel (busy_set_sel)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register values, pending bits, sweep cycles left.
    logic [XLEN-1:0] m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic            m_ready;
    int              m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0;
            m_left  <= NREGS - 1;
            m_busy  <= '0;
            for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
        end else if (!m_ready) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_ready <= 1'b1;
        end else begin
            logic [NREGS-1:0] nb;
            nb = m_busy;
            if (wen && regW_sel != 0) m_regs[regW_sel] <= regW_i;
            if (wen) nb[regW_sel] = 1'b0;
            if (busy_set_en && busy_set_sel != 0) nb[busy_set_sel] = 1'b1;
            m_busy <= nb;
        end
    end

    function automatic logic [AW-1:0] sel_of(int p);
        return rd_sel_i[p*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int p);
        logic [AW-1:0] a;
        a = sel_of(p);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen && regW_sel != 0 && a == regW_sel) return regW_i;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int p);
        logic [AW-1:0] a;
        a = sel_of(p);
        if (!m_ready) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wen && regW_sel != 0 && a == regW_sel) return busy_set_en && (busy_set_sel == a);
`endif
        return m_busy[a];
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_ready", {31'd0, ready_o}, {31'd0, m_ready});
        for (int p = 0; p < NREAD; p++) begin
            check($sformatf("model_data_p%0d", p), rd_data_o[p*XLEN +: XLEN], exp_data(p));
            check($sformatf("model_busy_p%0d", p), {31'd0, rd_busy_o[p]}, {31'd0, exp_busy(p)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen          = 1'b0;
        regW_sel     = '0;
        regW_i       = '0;
        busy_set_en  = 1'b0;
        busy_set_sel = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_sel_i = {a1, a0};
    endtask

    // Release reset just after an edge and count edges until ready_o is seen.
    task automatic release_and_wait(output int n);
        rst_n = 1'b1;
        n = 0;
        while (!ready_o && n < 200) begin
            step();
            n++;
        end
        if (!ready_o) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: ready_o still 0 after %0d cycles", n);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        set_rd(5'd0, 5'd0);
        #2;
        check("reset_ready", {31'd0, ready_o}, 32'd0);
        check("reset_busy", {30'd0, rd_busy_o}, 32'd0);
        check("reset_data", rd_data_o[31:0] | rd_data_o[63:32], 32'd0);
        step();
        step();

        // Writes and busy sets during the sweep must be ignored.
        wen = 1'b1; regW_sel = 5'd4; regW_i = 32'hFFFF_0000;
        busy_set_en = 1'b1; busy_set_sel = 5'd6;
        set_rd(5'd4, 5'd6);
        release_and_wait(n);
        check("sweep_cycles", n, 32'd31);
        idle_inputs();
        #1;
        check("clear_wr_r4", rd_data_o[31:0], 32'd0);
        check("clear_busy_r4", {31'd0, rd_busy_o[0]}, 32'd0);
        check("clear_busy_r6", {31'd0, rd_busy_o[1]}, 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a), AW'(NREGS - 1 - a));
            #1;
            check("swept_p0", rd_data_o[31:0], 32'd0);
            check("swept_p1", rd_data_o[63:32], 32'd0);
        end
        step();

        wen = 1'b1; regW_sel = 5'd5; regW_i = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        set_rd(5'd5, 5'd5);
        #1;
        check("r5_p0", rd_data_o[31:0], 32'hDEAD_BEEF);
        check("r5_p1", rd_data_o[63:32], 32'hDEAD_BEEF);

        wen = 1'b1; regW_sel = 5'd0; regW_i = 32'h0000_1234;
        step();
        idle_inputs();
        set_rd(5'd0, 5'd0);
        #1;
        check("r0_zero", rd_data_o[31:0], 32'd0);

        wen = 1'b1; regW_sel = 5'd7; regW_i = 32'hA5A5_A5A5;
        set_rd(5'd7, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r7_same_cycle", rd_data_o[31:0], 32'hA5A5_A5A5);
`else
        check("r7_same_cycle", rd_data_o[31:0], 32'd0);
`endif
        step();
        idle_inputs();
        #1;
        check("r7_next_cycle", rd_data_o[31:0], 32'hA5A5_A5A5);

        busy_set_en = 1'b1; busy_set_sel = 5'd9;
        step();
        idle_inputs();
        set_rd(5'd9, 5'd9);
        #1;
        check("r9_busy_set", {31'd0, rd_busy_o[0]}, 32'd1);
        wen = 1'b1; regW_sel = 5'd9; regW_i = 32'h0000_0099;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r9_busy_during_wr", {31'd0, rd_busy_o[0]}, 32'd0);
`else
        check("r9_busy_during_wr", {31'd0, rd_busy_o[0]}, 32'd1);
`endif
        step();
        idle_inputs();
        #1;
        check("r9_busy_cleared", {31'd0, rd_busy_o[0]}, 32'd0);
        wen = 1'b1; regW_sel = 5'd9; regW_i = 32'h0000_0077;
        busy_set_en = 1'b1; busy_set_sel = 5'd9;
        step();
        idle_inputs();
        #1;
        check("r9_set_wins", {31'd0, rd_busy_o[0]}, 32'd1);
        check("r9_data", rd_data_o[31:0], 32'h0000_0077);

        wen = 1'b1; regW_sel = 5'd3; regW_i = 32'h0000_0055;
        step();
        idle_inputs();
        set_rd(5'd3, 5'd9);
        #1;
        check("r3_written", rd_data_o[31:0], 32'h0000_0055);
        rst_n = 1'b0;
        #1;
        check("midrun_ready", {31'd0, ready_o}, 32'd0);
        check("midrun_busy", {30'd0, rd_busy_o}, 32'd0);
        step();
        release_and_wait(n);
        check("resweep_cycles", n, 32'd31);
        #1;
        check("r3_after_resweep", rd_data_o[31:0], 32'd0);
        check("r9_busy_after_resweep", {31'd0, rd_busy_o[1]}, 32'd0);

        // Random traffic; the negedge compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            wen          = ($urandom_range(0, 2) != 0);
            regW_sel     = AW'($urandom_range(0, 15));
            regW_i       = $urandom;
            busy_set_en  = ($urandom_range(0, 3) == 0);
            busy_set_sel = AW'($urandom_range(0, 15));
            rd_sel_i[AW-1:0]    = ($urandom_range(0, 3) == 0) ? regW_sel : AW'($urandom_range(0, 15));
            rd_sel_i[2*AW-1:AW] = ($urandom_range(0, 3) == 0) ? busy_set_sel : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with hardwired zero register, post-reset clear sweep, per-register busy scoreboard and optional write-to-read bypass. It is the successor to the core's two-read/one-write register file and sits in the decode stage: read ports feed operand selection, the write port is driven by writeback, and the scoreboard is driven by issue logic for long-latency (load) destinations. Storage has no reset so it maps to distributed RAM. A sequencer zeroes it after reset instead.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, register count (power of two, >= 2); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (>= 1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ready_o  output  1  high once the clear sweep has finished
- wen  input  1  write enable
- regW_sel  input  AW  write address
- regW_i  input  XLEN  write data
- rd_sel_i  input  NREAD*AW  read addresses, port p at [p*AW +: AW]
- rd_data_o  output  NREAD*XLEN  read data, port p at [p*XLEN +: XLEN]
- rd_busy_o  output  NREAD  scoreboard bit of each read address
- busy_set_en  input  1  mark a register pending
- busy_set_sel  input  AW  register to mark

## Operation
- Reset is asynchronous and active-low. One clock.
- FSM states: CLEAR and RUN.
- Reset forces CLEAR, the sweep counter to 1, ready_o=0 and busy vector to all-zero, asynchronously.
- CLEAR:
  - Each cycle writes 0 to register[counter] and increments the counter.
  - On counter==NREGS-1 the write occurs and the FSM moves to RUN.
  - External wen and busy_set_en are ignored.
  - rd_data_o is all-zero and rd_busy_o is all-zero.
- RUN:
  - ready_o=1.
  - Writes occur when wen=1 and regW_sel!=0.
  - Writes to register 0 are dropped.
- Reads are combinational. Port p returns 0 when its address is 0, otherwise register[addr].
- Scoreboard in RUN:
  - A write with wen=1 clears busy[regW_sel].
  - busy_set_en=1 sets busy[busy_set_sel].
  - If the set and the clear target the same register in the same cycle, the set wins and busy stays 1.
  - busy[0] is never set.
- rd_busy_o[p] = busy[rd_sel p], combinational, reflects the registered vector.
- Reset mid-operation, including during CLEAR, restarts the sweep from register 1.

## Timing
- Reset values: ready_o=0, rd_busy_o=0, rd_data_o=0.
- Clear sweep: ready_o rises on the edge after NREGS-1 CLEAR cycles (31 cycles for NREGS=32). The first RUN write is accepted on that cycle.
- Write latency: the value is visible on read ports in the cycle after the write edge (without bypass).
- Busy latency: a set or clear shows on rd_busy_o in the cycle after the edge.
- Multiple read ports addressing the same register return identical data.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, if wen=1, regW_sel!=0 and rd_sel p==regW_sel, rd_data_o[p]=regW_i in the same cycle.
  - rd_busy_o[p] is forced to 0 in that cycle, unless busy_set_en targets the same register.
- REGFILE_BYPASS_EN undefined:
  - Read data is the old value in that cycle.
  - rd_busy_o shows the registered busy bit.

## Structure
- Shared core package holds the FSM state enum (RF_CLEAR, RF_RUN) and the default XLEN/NREGS constants.
- Single module, no sub-modules. The per-port read/bypass mux is a generate loop.

## Test plan
- Reset then idle: ready_o low for exactly 31 cycles (NREGS=32), then high. Every register on every port reads 0x00000000.
- Write 0xDEADBEEF to r5, read r5 on port 0 and port 1 the next cycle: both return 0xDEADBEEF. Write 0x1234 to r0: r0 still reads 0.
- Same-cycle write r7=0xA5A5A5A5 and read r7:
  - With REGFILE_BYPASS_EN: 0xA5A5A5A5 that cycle.
  - Without: old value that cycle, 0xA5A5A5A5 the next.
- busy_set r9, next cycle rd_busy=1 on r9. Write r9: busy clears the next cycle. Simultaneous set and write of r9: busy stays 1.
- wen=1 and busy_set_en=1 during CLEAR: no effect. After ready_o, the target registers read 0 and are not busy.
- Assert rst_n low mid-RUN after writing r3=0x55: ready_o drops immediately and busy clears. After the re-sweep, r3 reads 0.
